display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// ============================================================================
// display_scan_ctrl : time-multiplexed seven-segment scan with blanking
// Revision: 1.0
// ============================================================================
`default_nettype none

module display_scan_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        load,
  input  logic [5*N_DIGITS-1:0]       data_in,
  input  logic [N_DIGITS-1:0]         blank_in,
  output logic                        load_ack,
  output logic [4:0]                  code,
  output logic [N_DIGITS-1:0]         an_n,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        frame_done
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [5*N_DIGITS-1:0]   pend_val_q;
  logic [N_DIGITS-1:0]     pend_blank_q;
  logic                    pend_flag_q;
  logic [5*N_DIGITS-1:0]   act_val_q,   act_val_d;
  logic [N_DIGITS-1:0]     act_blank_q, act_blank_d;
  logic [IDX_W-1:0]        idx_inc;
  logic                    slot_end;
  logic                    wrap;
  logic                    xfer;

  // A transfer edge is any entry into BLANK at digit 0 (wrap or power-on from OFF).
  always_comb begin
    slot_end    = (state_q == S_DRIVE) && (cnt_q == CNT_W'(TICK_DIV - 1));
    wrap        = slot_end && (digit_idx == IDX_W'(N_DIGITS - 1));
    idx_inc     = wrap ? '0 : digit_idx + IDX_W'(1);
    xfer        = en && ((state_q == S_OFF) || wrap);
    act_val_d   = act_val_q;
    act_blank_d = act_blank_q;
    if (xfer) begin
      if (load) begin
        act_val_d   = data_in;
        act_blank_d = blank_in;
      end else if (pend_flag_q) begin
        act_val_d   = pend_val_q;
        act_blank_d = pend_blank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_OFF;
      cnt_q        <= '0;
      digit_idx    <= '0;
      an_n         <= '1;
      code         <= 5'd0;
      load_ack     <= 1'b0;
      frame_done   <= 1'b0;
      pend_val_q   <= '0;
      pend_blank_q <= '1;
      pend_flag_q  <= 1'b0;
      act_val_q    <= '0;
      act_blank_q  <= '1;
    end else begin
      load_ack    <= load;
      frame_done  <= 1'b0;
      act_val_q   <= act_val_d;
      act_blank_q <= act_blank_d;

      if (xfer) begin
        pend_flag_q <= 1'b0;
      end else if (load) begin
        pend_val_q   <= data_in;
        pend_blank_q <= blank_in;
        pend_flag_q  <= 1'b1;
      end

      if (!en) begin
        state_q   <= S_OFF;
        cnt_q     <= '0;
        digit_idx <= '0;
        an_n      <= '1;
        code      <= 5'd0;
      end else begin
        case (state_q)
          S_OFF: begin
            state_q   <= S_BLANK;
            cnt_q     <= '0;
            digit_idx <= '0;
            an_n      <= '1;
            code      <= act_val_d[4:0];
          end
          S_BLANK: begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
              state_q <= S_DRIVE;
              an_n    <= act_blank_q[digit_idx] ? '1
                                                : ~(N_DIGITS'(1) << digit_idx);
            end
          end
          S_DRIVE: begin
            if (slot_end) begin
              state_q    <= S_BLANK;
              cnt_q      <= '0;
              digit_idx  <= idx_inc;
              an_n       <= '1;
              code       <= act_val_d[5*int'(idx_inc) +: 5];
              frame_done <= wrap;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            an_n    <= '1;
            code    <= 5'd0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// ============================================================================
// tb_display_scan_ctrl : directed checks of scan timing, loads, blanking, reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [19:0] data_in;
  logic [3:0]  blank_in;
  logic        load_ack;
  logic [4:0]  code;
  logic [3:0]  an_n;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  display_scan_ctrl #(
    .N_DIGITS  (4),
    .TICK_DIV  (10),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .data_in    (data_in),
    .blank_in   (blank_in),
    .load_ack   (load_ack),
    .code       (code),
    .an_n       (an_n),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Cycles m0..m1 of slot k: dark for m<2, lit pattern afterwards.
  task automatic run_part(input int k, input logic [4:0] c, input logic [3:0] lit,
                          input logic fd0, input int m0, input int m1);
    for (int m = m0; m <= m1; m++) begin
      step();
      check($sformatf("an_n s%0d m%0d", k, m), an_n, (m < 2) ? 4'hF : lit);
      check($sformatf("code s%0d m%0d", k, m), code, c);
      check($sformatf("idx s%0d m%0d", k, m), digit_idx, k);
      check($sformatf("fdone s%0d m%0d", k, m), frame_done, (m == 0) ? fd0 : 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; data_in = '0; blank_in = '0;
    repeat (2) @(negedge clk);
    check("rst an_n", an_n, 4'hF);
    check("rst code", code, 5'd0);
    check("rst idx", digit_idx, 2'd0);
    check("rst ack", load_ack, 1'b0);
    check("rst fdone", frame_done, 1'b0);
    rst_n = 1'b1;
    step();
    check("off an_n", an_n, 4'hF);

    // Initial load 4-3-2-1, display still off
    load = 1'b1; data_in = {5'd4, 5'd3, 5'd2, 5'd1}; blank_in = 4'b0000;
    step();
    check("ack1", load_ack, 1'b1);
    load = 1'b0;
    step();
    check("ack1 drop", load_ack, 1'b0);
    check("off code", code, 5'd0);

    // Frame 1 from OFF, frame 2 begins with frame_done
    en = 1'b1;
    run_part(0, 5'd1, 4'hE, 1'b0, 0, 9);
    run_part(1, 5'd2, 4'hD, 1'b0, 0, 9);
    run_part(2, 5'd3, 4'hB, 1'b0, 0, 9);
    run_part(3, 5'd4, 4'h7, 1'b0, 0, 9);
    run_part(0, 5'd1, 4'hE, 1'b1, 0, 9);
    run_part(1, 5'd2, 4'hD, 1'b0, 0, 9);

    // Load while digit 2 is lit: old values persist until next frame
    run_part(2, 5'd3, 4'hB, 1'b0, 0, 3);
    load = 1'b1; data_in = {5'd9, 5'd8, 5'd7, 5'd6};
    run_part(2, 5'd3, 4'hB, 1'b0, 4, 4);
    check("ack2", load_ack, 1'b1);
    load = 1'b0;
    run_part(2, 5'd3, 4'hB, 1'b0, 5, 5);
    check("ack2 drop", load_ack, 1'b0);
    run_part(2, 5'd3, 4'hB, 1'b0, 6, 9);
    run_part(3, 5'd4, 4'h7, 1'b0, 0, 9);
    run_part(0, 5'd6, 4'hE, 1'b1, 0, 9);
    run_part(1, 5'd7, 4'hD, 1'b0, 0, 9);
    run_part(2, 5'd8, 4'hB, 1'b0, 0, 9);
    run_part(3, 5'd9, 4'h7, 1'b0, 0, 9);

    // Load on the digit-0 entry edge bypasses to active, with digit 2 blanked
    load = 1'b1; data_in = {5'd13, 5'd12, 5'd11, 5'd17}; blank_in = 4'b0100;
    run_part(0, 5'd17, 4'hE, 1'b1, 0, 0);
    check("ack3", load_ack, 1'b1);
    load = 1'b0;
    run_part(0, 5'd17, 4'hE, 1'b0, 1, 9);
    run_part(1, 5'd11, 4'hD, 1'b0, 0, 9);
    run_part(2, 5'd12, 4'hF, 1'b0, 0, 9);
    run_part(3, 5'd13, 4'h7, 1'b0, 0, 9);
    run_part(0, 5'd17, 4'hE, 1'b1, 0, 9);

    // Disable mid DRIVE of digit 1
    run_part(1, 5'd11, 4'hD, 1'b0, 0, 4);
    en = 1'b0;
    step();
    check("dis an_n", an_n, 4'hF);
    check("dis fdone", frame_done, 1'b0);
    check("dis idx", digit_idx, 2'd0);
    check("dis code", code, 5'd0);
    step();
    check("dis an_n2", an_n, 4'hF);
    check("dis fdone2", frame_done, 1'b0);
    en = 1'b1;
    run_part(0, 5'd17, 4'hE, 1'b0, 0, 9);
    run_part(1, 5'd11, 4'hD, 1'b0, 0, 9);
    run_part(2, 5'd12, 4'hF, 1'b0, 0, 5);

    // Async reset between edges, with an un-acked load in flight
    load = 1'b1; data_in = {5'd21, 5'd22, 5'd23, 5'd24}; blank_in = 4'b0000;
    #2 rst_n = 1'b0;
    #1;
    check("arst an_n", an_n, 4'hF);
    check("arst code", code, 5'd0);
    check("arst idx", digit_idx, 2'd0);
    check("arst ack", load_ack, 1'b0);
    check("arst fdone", frame_done, 1'b0);
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_part(0, 5'd0, 4'hF, 1'b0, 0, 9);
    run_part(1, 5'd0, 4'hF, 1'b0, 0, 3);
    check("post ack", load_ack, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
